// File: rtl/memory_access.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : memory_access
// Brief    : RISC-V memory stage with load/store FSM and lane steering.
// Revision : 1.0
// ============================================================================
module memory_access (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] alu_result_i,
    input  logic [31:0] rs2_i,
    output logic        stall_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] result_o,
    output logic        fault_o
);

    localparam logic [6:0] c_op_load  = 7'b0000011;
    localparam logic [6:0] c_op_store = 7'b0100011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_instr;
    logic [31:0] r_addr;

    logic        w_is_load;
    logic        w_is_store;
    logic        w_f3_ok;
    logic        w_misalign;
    logic        w_fault;
    logic        w_mem_ok;
    logic [2:0]  w_funct3;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_shift;
    logic [31:0] w_load_data;

    assign w_funct3   = instr_i[14:12];
    assign w_is_load  = (instr_i[6:0] == c_op_load);
    assign w_is_store = (instr_i[6:0] == c_op_store);

    always_comb begin
        w_f3_ok    = 1'b0;
        w_misalign = 1'b0;
        w_be       = 4'b1111;
        w_wdata    = 32'd0;
        if (w_is_load) begin
            w_f3_ok = (w_funct3 == 3'b000) || (w_funct3 == 3'b001) || (w_funct3 == 3'b010) ||
                      (w_funct3 == 3'b100) || (w_funct3 == 3'b101);
        end else if (w_is_store) begin
            w_f3_ok = (w_funct3 == 3'b000) || (w_funct3 == 3'b001) || (w_funct3 == 3'b010);
        end
        case (w_funct3[1:0])
            2'b00: begin
                w_be = 4'b0001 << alu_result_i[1:0];
                if (w_is_store) w_wdata = {4{rs2_i[7:0]}};
            end
            2'b01: begin
                w_misalign = alu_result_i[0];
                w_be       = alu_result_i[1] ? 4'b1100 : 4'b0011;
                if (w_is_store) w_wdata = {2{rs2_i[15:0]}};
            end
            default: begin
                w_misalign = (alu_result_i[1:0] != 2'b00);
                w_be       = 4'b1111;
                if (w_is_store) w_wdata = rs2_i;
            end
        endcase
    end

    assign w_fault  = (w_is_load || w_is_store) && (!w_f3_ok || w_misalign);
    assign w_mem_ok = (w_is_load || w_is_store) && !w_fault;

    // Shifting the returned word down by the byte offset puts the selected
    // byte or halfword lane at bit 0 for every legal alignment.
    assign w_shift = dmem_rdata_i >> {r_addr[1:0], 3'b000};

    always_comb begin
        case (r_instr[14:12])
            3'b000:  w_load_data = {{24{w_shift[7]}}, w_shift[7:0]};
            3'b001:  w_load_data = {{16{w_shift[15]}}, w_shift[15:0]};
            3'b100:  w_load_data = {24'd0, w_shift[7:0]};
            3'b101:  w_load_data = {16'd0, w_shift[15:0]};
            default: w_load_data = w_shift;
        endcase
    end

    always_comb begin
        case (r_state)
            IDLE:    stall_o = valid_i && w_mem_ok;
            REQ:     stall_o = !(dmem_gnt_i && dmem_we_o);
            RESP:    stall_o = !dmem_rvalid_i;
            default: stall_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_instr      <= 32'd0;
            r_addr       <= 32'd0;
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= 32'd0;
            dmem_be_o    <= 4'd0;
            dmem_wdata_o <= 32'd0;
            valid_o      <= 1'b0;
            instr_o      <= 32'd0;
            result_o     <= 32'd0;
            fault_o      <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (valid_i) begin
                        if (w_mem_ok) begin
                            r_instr      <= instr_i;
                            r_addr       <= alu_result_i;
                            dmem_req_o   <= 1'b1;
                            dmem_we_o    <= w_is_store;
                            dmem_addr_o  <= {alu_result_i[31:2], 2'b00};
                            dmem_be_o    <= w_be;
                            dmem_wdata_o <= w_wdata;
                            r_state      <= REQ;
                        end else begin
                            valid_o  <= 1'b1;
                            instr_o  <= instr_i;
                            result_o <= w_fault ? 32'd0 : alu_result_i;
                            fault_o  <= w_fault;
                        end
                    end
                end
                REQ: begin
                    if (dmem_gnt_i) begin
                        dmem_req_o   <= 1'b0;
                        dmem_we_o    <= 1'b0;
                        dmem_addr_o  <= 32'd0;
                        dmem_be_o    <= 4'd0;
                        dmem_wdata_o <= 32'd0;
                        if (dmem_we_o) begin
                            valid_o  <= 1'b1;
                            instr_o  <= r_instr;
                            result_o <= r_addr;
                            fault_o  <= 1'b0;
                            r_state  <= IDLE;
                        end else begin
                            r_state  <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (dmem_rvalid_i) begin
                        valid_o  <= 1'b1;
                        instr_o  <= r_instr;
                        result_o <= w_load_data;
                        fault_o  <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_memory_access.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_memory_access
// Brief    : Scoreboard bench for memory_access with a byte-level memory model.
// Revision : 1.0
// ============================================================================
module tb_memory_access;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i;
    logic [31:0] instr_i, alu_result_i, rs2_i;
    logic        stall_o, dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic [3:0]  dmem_be_o;
    logic        dmem_gnt_i, dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic        valid_o, fault_o;
    logic [31:0] instr_o, result_o;

    // Directed phase drives the memory side by hand, random phase uses the responder.
    bit          auto_resp = 1'b0;
    logic        d_gnt = 1'b0, d_rvalid = 1'b0;
    logic [31:0] d_rdata = 32'd0;
    logic        a_gnt = 1'b0, a_rvalid = 1'b0;
    logic [31:0] a_rdata = 32'd0;
    assign dmem_gnt_i    = auto_resp ? a_gnt    : d_gnt;
    assign dmem_rvalid_i = auto_resp ? a_rvalid : d_rvalid;
    assign dmem_rdata_i  = auto_resp ? a_rdata  : d_rdata;

    memory_access dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .instr_i(instr_i),
        .alu_result_i(alu_result_i), .rs2_i(rs2_i), .stall_o(stall_o),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt_i),
        .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i), .valid_o(valid_o),
        .instr_o(instr_o), .result_o(result_o), .fault_o(fault_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] result;
        logic        fault;
    } resp_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_t;

    resp_t       exp_q[$];
    req_t        req_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  mdl_mem[64];
    logic [31:0] rsp_mem[16];
    localparam logic [31:0] BASE = 32'h0000_0100;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: byte-addressed memory, sizes in bytes, little-endian.
    task automatic model(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] d);
        bit          is_ld, is_st, legal;
        int          size, lo, off;
        logic [2:0]  f3;
        logic [31:0] v;
        resp_t       r;
        req_t        q;
        f3    = ins[14:12];
        is_ld = (ins[6:0] == 7'h03);
        is_st = (ins[6:0] == 7'h23);
        r.instr = ins; r.result = a; r.fault = 1'b0;
        if (is_ld || is_st) begin
            legal = is_ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
            size  = 1 << f3[1:0];
            lo    = int'(a % 4);
            off   = int'(a - BASE);
            if (!legal || (a % size) != 0) begin
                r.result = 32'd0; r.fault = 1'b1;
            end else begin
                q.we = is_st; q.addr = a - (a % 4); q.be = 4'd0; q.wdata = 32'd0;
                for (int i = 0; i < size; i++) q.be[lo + i] = 1'b1;
                if (is_st) begin
                    for (int j = 0; j < 4; j++) q.wdata[8*j +: 8] = d[8*(j % size) +: 8];
                    for (int i = 0; i < size; i++) mdl_mem[off + i] = d[8*i +: 8];
                end else begin
                    v = 32'd0;
                    for (int i = 0; i < size; i++) v[8*i +: 8] = mdl_mem[off + i];
                    if (!f3[2] && size < 4 && v[8*size - 1]) v = v | (32'hFFFF_FFFF << (8*size));
                    r.result = v;
                end
                req_q.push_back(q);
            end
        end
        exp_q.push_back(r);
    endtask

    // Monitor: compares every completed instruction against the scoreboard.
    initial begin
        resp_t e;
        forever begin
            @(posedge clk); #1;
            if (valid_o) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_valid: instr_o %h with nothing pending", instr_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("instr_o", instr_o, e.instr);
                    chk("result_o", result_o, e.result);
                    chk("fault_o", {31'd0, fault_o}, {31'd0, e.fault});
                end
            end
        end
    end

    // Memory responder with random grant and response latency.
    initial begin
        bit   pend = 1'b0;
        int   cnt = 0;
        logic [3:0] idx = 4'd0;
        req_t q;
        forever begin
            @(negedge clk);
            if (auto_resp) begin
                a_gnt = 1'b0; a_rvalid = 1'b0; a_rdata = $urandom;
                if (pend) begin
                    if (cnt == 0) begin
                        a_rvalid = 1'b1; a_rdata = rsp_mem[idx]; pend = 1'b0;
                    end else cnt--;
                end else if (dmem_req_o) begin
                    if ($urandom_range(0, 2) == 0) begin
                        a_gnt = 1'b1;
                        if (req_q.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL unexpected_req: addr %h", dmem_addr_o);
                        end else begin
                            q = req_q.pop_front();
                            chk("req_we", {31'd0, dmem_we_o}, {31'd0, q.we});
                            chk("req_addr", dmem_addr_o, q.addr);
                            chk("req_be", {28'd0, dmem_be_o}, {28'd0, q.be});
                            chk("req_wdata", dmem_wdata_o, q.wdata);
                        end
                        idx = dmem_addr_o[5:2];
                        if (dmem_we_o) begin
                            for (int j = 0; j < 4; j++)
                                if (dmem_be_o[j]) rsp_mem[idx][8*j +: 8] = dmem_wdata_o[8*j +: 8];
                        end else begin
                            pend = 1'b1; cnt = $urandom_range(0, 2);
                        end
                    end
                end else if ($urandom_range(0, 7) == 0) begin
                    a_rvalid = 1'b1;
                    a_gnt    = 1'($urandom_range(0, 1));
                end
            end
        end
    end

    task automatic issue(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        @(negedge clk);
        valid_i = 1'b1; instr_i = ins; alu_result_i = a; rs2_i = d;
        model(ins, a, d);
        #4;
        while (stall_o) begin
            n++;
            if (n > 40) begin
                checks++; errors++;
                $display("FAIL stall_timeout: instr %h still stalled", ins);
                break;
            end
            @(negedge clk); #4;
        end
    endtask

    task automatic present(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        valid_i = 1'b1; instr_i = ins; alu_result_i = a; rs2_i = d;
    endtask

    task automatic direct_load(input logic [2:0] f3, input logic [31:0] expv);
        logic [31:0] ins;
        ins = {17'd0, f3, 5'd5, 7'h03};
        present(ins, 32'h0000_1003, 32'd0);
        exp_q.push_back('{instr: ins, result: expv, fault: 1'b0});
        @(negedge clk); #1;
        chk("lb_req", {31'd0, dmem_req_o}, 32'd1);
        chk("lb_addr", dmem_addr_o, 32'h0000_1000);
        chk("lb_be", {28'd0, dmem_be_o}, 32'h8);
        chk("lb_we", {31'd0, dmem_we_o}, 32'd0);
        d_gnt = 1'b1;
        @(negedge clk);
        d_gnt = 1'b0; d_rvalid = 1'b1; d_rdata = 32'h80FF_FF00; #1;
        chk("lb_stall_rvalid", {31'd0, stall_o}, 32'd0);
        @(negedge clk);
        d_rvalid = 1'b0; valid_i = 1'b0;
        chk("lb_valid_t3", {31'd0, valid_o}, 32'd1);
    endtask

    initial begin
        logic [31:0] ins, a, d;
        logic [2:0]  f3;
        int          kind, n;
        logic [2:0]  ld_f3[5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

        rst_n = 1'b0; valid_i = 1'b0; instr_i = 0; alu_result_i = 0; rs2_i = 0;
        repeat (2) @(negedge clk);
        chk("rst_stall", {31'd0, stall_o}, 0);
        chk("rst_req", {31'd0, dmem_req_o}, 0);
        chk("rst_we", {31'd0, dmem_we_o}, 0);
        chk("rst_addr", dmem_addr_o, 0);
        chk("rst_be", {28'd0, dmem_be_o}, 0);
        chk("rst_wdata", dmem_wdata_o, 0);
        chk("rst_valid", {31'd0, valid_o}, 0);
        chk("rst_instr", instr_o, 0);
        chk("rst_result", result_o, 0);
        chk("rst_fault", {31'd0, fault_o}, 0);
        rst_n = 1'b1;

        // ADD pass-through
        present(32'h0020_81B3, 32'h0000_1234, 32'd0);
        exp_q.push_back('{instr: 32'h0020_81B3, result: 32'h0000_1234, fault: 1'b0});
        #1 chk("add_stall", {31'd0, stall_o}, 0);
        @(negedge clk);
        valid_i = 1'b0;
        chk("add_valid_t1", {31'd0, valid_o}, 1);

        direct_load(3'b000, 32'hFFFF_FF80);
        direct_load(3'b100, 32'h0000_0080);

        // SH with grant delayed three cycles
        ins = {17'd0, 3'b001, 5'd0, 7'h23};
        present(ins, 32'h0000_2002, 32'hABCD_1234);
        exp_q.push_back('{instr: ins, result: 32'h0000_2002, fault: 1'b0});
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            chk("sh_req", {31'd0, dmem_req_o}, 1);
            chk("sh_addr", dmem_addr_o, 32'h0000_2000);
            chk("sh_be", {28'd0, dmem_be_o}, 32'hC);
            chk("sh_wdata", dmem_wdata_o, 32'h1234_1234);
            chk("sh_we", {31'd0, dmem_we_o}, 1);
            chk("sh_stall", {31'd0, stall_o}, 1);
        end
        @(negedge clk);
        d_gnt = 1'b1; #1;
        chk("sh_stall_gnt", {31'd0, stall_o}, 0);
        @(negedge clk);
        d_gnt = 1'b0; valid_i = 1'b0;
        chk("sh_valid", {31'd0, valid_o}, 1);
        chk("sh_req_drop", {31'd0, dmem_req_o}, 0);
        @(negedge clk);
        chk("sh_valid_once", {31'd0, valid_o}, 0);

        // Misaligned LW and illegal funct3
        for (int k = 0; k < 2; k++) begin
            ins = {17'd0, (k == 0) ? 3'b010 : 3'b011, 5'd3, 7'h03};
            present(ins, (k == 0) ? 32'h0000_2001 : 32'h0000_2000, 32'd0);
            exp_q.push_back('{instr: ins, result: 32'd0, fault: 1'b1});
            #1 chk("fault_stall", {31'd0, stall_o}, 0);
            @(negedge clk);
            valid_i = 1'b0;
            chk("fault_noreq", {31'd0, dmem_req_o}, 0);
            chk("fault_valid", {31'd0, valid_o}, 1);
        end

        // Reset while waiting for load data, then a stray rvalid
        present({17'd0, 3'b010, 5'd4, 7'h03}, 32'h0000_3000, 32'd0);
        @(negedge clk);
        d_gnt = 1'b1;
        @(negedge clk);
        d_gnt = 1'b0;
        #1 rst_n = 1'b0; valid_i = 1'b0;
        #1;
        chk("rstmid_req", {31'd0, dmem_req_o}, 0);
        chk("rstmid_stall", {31'd0, stall_o}, 0);
        chk("rstmid_valid", {31'd0, valid_o}, 0);
        chk("rstmid_result", result_o, 0);
        chk("rstmid_instr", instr_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        d_rvalid = 1'b1; d_rdata = 32'hDEAD_BEEF; #1;
        chk("stray_stall", {31'd0, stall_o}, 0);
        @(negedge clk);
        d_rvalid = 1'b0;
        chk("stray_valid", {31'd0, valid_o}, 0);
        chk("stray_req", {31'd0, dmem_req_o}, 0);

        // Randomized mixed traffic
        for (int i = 0; i < 64; i++) mdl_mem[i] = 8'($urandom);
        for (int w = 0; w < 16; w++)
            rsp_mem[w] = {mdl_mem[4*w+3], mdl_mem[4*w+2], mdl_mem[4*w+1], mdl_mem[4*w]};
        auto_resp = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                valid_i = 1'b0;
            end
            kind = $urandom_range(0, 7);
            d    = $urandom;
            if (kind <= 4) begin
                if (kind <= 2) f3 = ld_f3[$urandom_range(0, 4)];
                else           f3 = 3'($urandom_range(0, 2));
                if ($urandom_range(0, 9) == 0) f3 = 3'($urandom);
                a = BASE + 32'($urandom_range(0, 63));
                if ($urandom_range(0, 2) != 0) a = a & ~((32'd1 << f3[1:0]) - 1);
                ins = {$urandom} & 32'hFFFF_8F80;
                ins = ins | {17'd0, f3, 5'd0, (kind <= 2) ? 7'h03 : 7'h23};
            end else begin
                ins = $urandom;
                if (ins[6:0] == 7'h03 || ins[6:0] == 7'h23) ins[6:0] = 7'h33;
                a = $urandom;
            end
            issue(ins, a, d);
        end
        @(negedge clk);
        valid_i = 1'b0;
        n = 0;
        while ((exp_q.size() != 0 || req_q.size() != 0) && n < 100) begin
            @(negedge clk); n++;
        end
        chk("drain_resp", exp_q.size(), 0);
        chk("drain_req", req_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
